// File: rtl/bus_irq_ctrl_if.sv
// Address/control and interrupt handshake lines between the processor
// bus and the interrupt controller.
interface bus_irq_ctrl_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/bus_irq_ctrl.sv
// Prioritised interrupt controller: PEND/MASK/MODE/VECTOR at BASE_ADDR+0..3.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchroniser on every source.
module bus_irq_ctrl #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter logic [7:0] MASK_RST  = 8'hFF,
  parameter logic [7:0] MODE_RST  = 8'hFF
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       BUS_DATA,
  bus_irq_ctrl_if.slave    bus,
  input  logic [N_SRC-1:0] SRC_RAISE,
  output logic [N_SRC-1:0] SRC_ACK
);

  typedef enum logic [1:0] {
    IDLE,
    RAISED,
    HOLDOFF
  } state_t;

  state_t r_state, w_state_nx;

  logic [N_SRC-1:0] w_src, r_smp, r_prev;
  logic [N_SRC-1:0] r_pend, r_mask, r_mode, r_ack;
  logic [N_SRC-1:0] w_hit, w_edge, w_clr, w_pend_nx;
  logic [N_SRC-1:0] w_cur_oh, w_wdata;
  logic [2:0]       r_cur, w_idx;
  logic [7:0]       w_off, w_vec, w_rmux;
  logic [7:0]       w_pend8, w_mask8, w_mode8;
  logic [7:0]       r_rdata;
  logic             r_rd_en, w_wr, w_rd, w_sel;
  logic             w_cur_hit, w_ack_go, w_latch;
  logic             w_unused;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] r_s1, r_s2;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= SRC_RAISE;
      r_s2 <= r_s1;
    end
  end

  assign w_src = r_s2;
`else
  assign w_src = SRC_RAISE;
`endif

  assign w_off   = bus.BUS_ADDR - BASE_ADDR;
  assign w_sel   = (w_off < 8'd4);
  assign w_wr    = w_sel & bus.BUS_WE;
  assign w_rd    = w_sel & ~bus.BUS_WE;
  assign w_wdata = BUS_DATA[N_SRC-1:0];
  assign w_unused = &{1'b0, BUS_DATA};

  assign w_hit  = r_pend & r_mask;
  assign w_edge = r_smp & ~r_prev;

  always_comb begin
    w_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_hit[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_cur_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_cur_oh[i] = (r_cur == 3'(i));
    end
  end

  assign w_cur_hit = |(w_hit & w_cur_oh);
  assign w_vec = (|w_hit) ? {5'b10000, w_idx} : 8'h00;

  always_comb begin
    w_pend8 = '0;
    w_mask8 = '0;
    w_mode8 = '0;
    w_pend8[N_SRC-1:0] = r_pend;
    w_mask8[N_SRC-1:0] = r_mask;
    w_mode8[N_SRC-1:0] = r_mode;
  end

  always_comb begin
    w_rmux = 8'h00;
    unique case (w_off[1:0])
      2'd0: w_rmux = w_pend8;
      2'd1: w_rmux = w_mask8;
      2'd2: w_rmux = w_mode8;
      2'd3: w_rmux = w_vec;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_ack_go   = 1'b0;
    w_latch    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_hit) begin
          w_state_nx = RAISED;
          w_latch    = 1'b1;
        end
      end
      RAISED: begin
        if (bus.BUS_INTERRUPT_ACK) begin
          w_state_nx = HOLDOFF;
          w_ack_go   = 1'b1;
        end else if (!w_cur_hit) begin
          w_state_nx = IDLE;
        end
      end
      HOLDOFF: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // New edges are OR-ed in after clearing, so a coincident edge survives.
  assign w_clr = ((w_wr && w_off[1:0] == 2'd0) ? w_wdata : '0)
               | (w_ack_go ? w_cur_oh : '0);
  assign w_pend_nx = (r_mode & ((r_pend & ~w_clr) | w_edge))
                   | (~r_mode & r_smp);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_smp   <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_mask  <= MASK_RST[N_SRC-1:0];
      r_mode  <= MODE_RST[N_SRC-1:0];
      r_ack   <= '0;
      r_cur   <= '0;
      r_rdata <= '0;
      r_rd_en <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_smp   <= w_src;
      r_prev  <= r_smp;
      r_pend  <= w_pend_nx;
      r_ack   <= w_ack_go ? w_cur_oh : '0;
      r_rd_en <= w_rd;
      if (w_latch) r_cur <= w_idx;
      if (w_rd) r_rdata <= w_rmux;
      if (w_wr && w_off[1:0] == 2'd1) r_mask <= w_wdata;
      if (w_wr && w_off[1:0] == 2'd2) r_mode <= w_wdata;
    end
  end

  assign BUS_DATA = r_rd_en ? r_rdata : {8{1'bz}};
  assign bus.BUS_INTERRUPT_RAISE = (r_state == RAISED);
  assign SRC_ACK = r_ack;

endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Directed bench for bus_irq_ctrl: register table plus handshake sequences.
// BUS_DATA is pulled high so a released bus reads 8'hFF.
module tb_bus_irq_ctrl;

  logic       CLK;
  logic       RESET;
  logic [3:0] SRC_RAISE;
  logic [3:0] SRC_ACK;
  logic       r_drv;
  logic [7:0] r_wd;
  tri1  [7:0] BUS_DATA;

  int n_assert;
  int n_fail;

  bus_irq_ctrl_if bus ();

  assign BUS_DATA = r_drv ? r_wd : 8'hzz;

  bus_irq_ctrl #(
    .N_SRC(4),
    .BASE_ADDR(8'hB0),
    .MASK_RST(8'hFF),
    .MODE_RST(8'hFF)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BUS_DATA(BUS_DATA),
    .bus(bus),
    .SRC_RAISE(SRC_RAISE),
    .SRC_ACK(SRC_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b0;
    tick();
    d = BUS_DATA;
    bus.BUS_ADDR = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b1;
    r_wd  = d;
    r_drv = 1'b1;
    tick();
    bus.BUS_WE   = 1'b0;
    r_drv = 1'b0;
    bus.BUS_ADDR = 8'h00;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic do_ack(input string nm, input logic [3:0] exp);
    bus.BUS_INTERRUPT_ACK = 1'b1;
    tick();
    bus.BUS_INTERRUPT_ACK = 1'b0;
    chk({nm, "_srcack"}, {4'h0, SRC_ACK}, {4'h0, exp});
    chk({nm, "_raise0"}, {7'h0, bus.BUS_INTERRUPT_RAISE}, 8'h00);
  endtask

  task automatic chk_raise(input string nm, input logic exp);
    chk(nm, {7'h0, bus.BUS_INTERRUPT_RAISE}, {7'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    n_assert = 0;
    n_fail   = 0;
    RESET = 1'b0;
    SRC_RAISE = '0;
    r_drv = 1'b0;
    r_wd  = '0;
    bus.BUS_ADDR = 8'h00;
    bus.BUS_WE   = 1'b0;
    bus.BUS_INTERRUPT_ACK = 1'b0;

    vecs[0]  = '{1'b0, 8'hB1, 8'h00, 8'h0F};
    vecs[1]  = '{1'b0, 8'hB2, 8'h00, 8'h0F};
    vecs[2]  = '{1'b0, 8'hB3, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 8'hB0, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 8'hB3, 8'hFF, 8'h00};
    vecs[5]  = '{1'b0, 8'hB3, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 8'hB1, 8'hF3, 8'h00};
    vecs[7]  = '{1'b0, 8'hB1, 8'h00, 8'h03};
    vecs[8]  = '{1'b1, 8'hB2, 8'hA5, 8'h00};
    vecs[9]  = '{1'b0, 8'hB2, 8'h00, 8'h05};
    vecs[10] = '{1'b0, 8'hB4, 8'h00, 8'hFF};
    vecs[11] = '{1'b0, 8'hAF, 8'h00, 8'hFF};
    vecs[12] = '{1'b1, 8'hB1, 8'h0F, 8'h00};
    vecs[13] = '{1'b1, 8'hB2, 8'h0F, 8'h00};
    vecs[14] = '{1'b0, 8'hB1, 8'h00, 8'h0F};
    vecs[15] = '{1'b0, 8'hB2, 8'h00, 8'h0F};

    #12;
    chk_raise("rst_raise", 1'b0);
    chk("rst_srcack", {4'h0, SRC_ACK}, 8'h00);
    chk("rst_bus_z", BUS_DATA, 8'hFF);
    @(posedge CLK);
    #1 RESET = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, d);
        chk($sformatf("vec%0d_rd", i), d, vecs[i].exp);
        tick();
        chk($sformatf("vec%0d_z", i), BUS_DATA, 8'hFF);
      end
    end

    // Single pulse on source 2
    SRC_RAISE = 4'b0100;
    tick();
    SRC_RAISE = 4'b0000;
    chk_raise("s2_n", 1'b0);
    tick();
    chk_raise("s2_n1", 1'b0);
    tick();
    chk_raise("s2_n2", 1'b1);
    rd_chk("s2_vec", 8'hB3, 8'h82);
    rd_chk("s2_pend", 8'hB0, 8'h04);
    do_ack("s2", 4'b0100);
    tick();
    chk("s2_ack_once", {4'h0, SRC_ACK}, 8'h00);
    chk_raise("s2_low", 1'b0);
    rd_chk("s2_pend0", 8'hB0, 8'h00);
    chk_raise("s2_idle", 1'b0);

    // Sources 3 and 1 together: 1 first, then 3
    SRC_RAISE = 4'b1010;
    tick();
    SRC_RAISE = 4'b0000;
    tick();
    tick();
    chk_raise("p31_raise", 1'b1);
    rd_chk("p31_vec1", 8'hB3, 8'h81);
    do_ack("p31a", 4'b0010);
    tick();
    chk_raise("p31_hold", 1'b0);
    tick();
    chk_raise("p31_again", 1'b1);
    rd_chk("p31_vec3", 8'hB3, 8'h83);
    do_ack("p31b", 4'b1000);
    tick();
    tick();
    chk_raise("p31_done", 1'b0);
    rd_chk("p31_pend", 8'hB0, 8'h00);

    // Masked source stays pending until unmasked
    bus_write(8'hB1, 8'h0E);
    SRC_RAISE = 4'b0001;
    tick();
    SRC_RAISE = 4'b0000;
    tick();
    tick();
    tick();
    chk_raise("msk_quiet", 1'b0);
    rd_chk("msk_pend", 8'hB0, 8'h01);
    rd_chk("msk_vec", 8'hB3, 8'h00);
    bus_write(8'hB1, 8'h0F);
    chk_raise("msk_w", 1'b0);
    tick();
    chk_raise("msk_w1", 1'b1);
    do_ack("msk", 4'b0001);
    tick();
    tick();

    // Level mode on source 1
    bus_write(8'hB2, 8'h00);
    SRC_RAISE = 4'b0010;
    tick();
    chk_raise("lvl_n", 1'b0);
    tick();
    chk_raise("lvl_n1", 1'b0);
    tick();
    chk_raise("lvl_n2", 1'b1);
    rd_chk("lvl_pend", 8'hB0, 8'h02);
    do_ack("lvl", 4'b0010);
    tick();
    chk_raise("lvl_hold", 1'b0);
    tick();
    chk_raise("lvl_back", 1'b1);
    SRC_RAISE = 4'b0000;
    tick();
    chk_raise("lvl_rel1", 1'b1);
    tick();
    chk_raise("lvl_rel2", 1'b1);
    chk("lvl_noack2", {4'h0, SRC_ACK}, 8'h00);
    tick();
    chk_raise("lvl_drop", 1'b0);
    chk("lvl_noack3", {4'h0, SRC_ACK}, 8'h00);
    rd_chk("lvl_pend0", 8'hB0, 8'h00);

    // Edge coincides with W1C; then reset while raised
    bus_write(8'hB2, 8'h0D);
    bus_write(8'hB1, 8'h05);
    SRC_RAISE = 4'b0001;
    tick();
    SRC_RAISE = 4'b0000;
    bus.BUS_ADDR = 8'hB0;
    bus.BUS_WE   = 1'b1;
    r_wd  = 8'h01;
    r_drv = 1'b1;
    tick();
    bus.BUS_WE   = 1'b0;
    r_drv = 1'b0;
    bus.BUS_ADDR = 8'h00;
    rd_chk("w1c_set_wins", 8'hB0, 8'h01);
    chk_raise("w1c_raise", 1'b1);
    RESET = 1'b0;
    #1;
    chk_raise("arst_raise", 1'b0);
    chk("arst_srcack", {4'h0, SRC_ACK}, 8'h00);
    chk("arst_bus_z", BUS_DATA, 8'hFF);
    tick();
    RESET = 1'b1;
    tick();
    rd_chk("arst_pend", 8'hB0, 8'h00);
    rd_chk("arst_mask", 8'hB1, 8'h0F);
    rd_chk("arst_mode", 8'hB2, 8'h0F);
    rd_chk("arst_vec", 8'hB3, 8'h00);
    tick();
    chk_raise("arst_idle", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_irq_ctrl.md
Name: bus_irq_ctrl

Overview:
- Parametrised interrupt controller on the 8-bit processor bus.
- Collects N_SRC peripheral raise lines (timer, mouse, future blocks) into one prioritised processor interrupt line, and returns a per-source ACK pulse.
- Per-source mask, edge/level mode, pending status and a vector register are software-visible at BASE_ADDR..BASE_ADDR+3.
- Replaces hard-wiring each peripheral to a dedicated processor interrupt bit.

Parameters:
N_SRC, 4, number of interrupt sources, legal 1..8; register bits [7:N_SRC] read 0 and ignore writes
BASE_ADDR, 8'hB0, bus address of register 0; occupies BASE_ADDR..BASE_ADDR+3
MASK_RST, 8'hFF, reset value of MASK (bits above N_SRC ignored)
MODE_RST, 8'hFF, reset value of MODE (1 = edge, 0 = level)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
BUS_DATA  inout  8  shared data bus; driven only during register reads
BUS_ADDR  in  8  bus address
BUS_WE  in  1  bus write enable
SRC_RAISE  in  N_SRC  peripheral interrupt requests
SRC_ACK  out  N_SRC  one-cycle acknowledge pulse to the serviced source
BUS_INTERRUPT_RAISE  out  1  to processor interrupt input
BUS_INTERRUPT_ACK  in  1  processor acknowledge pulse

Behaviour:
- Reset (RESET=0, async):
  - PEND=0, MASK=MASK_RST, MODE=MODE_RST.
  - BUS_INTERRUPT_RAISE=0, SRC_ACK=0, BUS_DATA released (Z), read-data register=0.
- Registers, at offsets from BASE_ADDR:
  - +0 PEND: read returns pending bits; write is write-1-to-clear.
  - +1 MASK: read/write; 1 = enabled.
  - +2 MODE: read/write; 1 = edge, 0 = level.
  - +3 VECTOR: read-only; bit7 = valid (any PEND&MASK), bits[2:0] = index of winner; reads 8'h00 when not valid. Writes ignored.
- Bus read:
  - Address in range with BUS_WE=0 at edge n: data registered, and BUS_DATA driven on cycle n+1 only.
  - Otherwise Z. Read has no side effects.
- Bus write: BUS_WE=1 with address in range; takes effect at that clock edge.
- Pending, per bit i:
  - Edge mode: set on a rising SRC_RAISE[i] (compared with a registered previous sample).
  - Level mode: PEND[i] equals the registered SRC_RAISE[i] each cycle; W1C and ACK have no lasting effect while the level stays high.
  - Set beats clear: an edge arriving in the same cycle as a W1C or ACK clear leaves the bit set.
  - Mode change edge to level takes effect next cycle. The prev-sample register keeps updating, so no spurious edge is seen.
- Priority: fixed, lowest index wins among PEND&MASK.
- Handshake FSM, states IDLE, RAISED, HOLDOFF:
  - IDLE: if any PEND&MASK, go to RAISED; BUS_INTERRUPT_RAISE=1 from the next edge. The winner index is latched as CUR.
  - RAISED: CUR does not change, even if a higher-priority source becomes pending. On BUS_INTERRUPT_ACK:
    - SRC_ACK[CUR] pulses for 1 cycle.
    - PEND[CUR] is cleared (edge mode).
    - RAISE drops.
    - Go to HOLDOFF.
  - RAISED, no ACK: if CUR becomes unpending or masked (W1C, mask write, level drop), RAISE drops and the FSM returns to IDLE without an ACK pulse.
  - HOLDOFF: lasts 1 cycle, RAISE=0, then IDLE. This gives the processor a guaranteed low cycle between interrupts.
  - ACK seen in IDLE or HOLDOFF is ignored; no SRC_ACK pulse.
- Latency, no sync: SRC_RAISE rises, sampled at edge n:
  - PEND set at n+1.
  - FSM enters RAISED and BUS_INTERRUPT_RAISE=1 at n+2.
- Masking: a pending but masked bit stays pending and raises as soon as it is unmasked.

Optional Feature:
- Macro: IRQ_CTRL_SYNC_EN
- Defined: each SRC_RAISE bit passes through a 2-flop synchroniser before edge/level detection. All source-to-RAISE latencies grow by 2 cycles (n+4).
- Undefined: sources are sampled directly; sources must be synchronous to CLK.
- Register map and FSM are identical in both builds.

Test Plan:
- Reset, then read BASE+1 and BASE+2 -> 8'h0F and 8'h0F (N_SRC=4); BASE+3 -> 8'h00; BUS_DATA is Z whenever no read is addressed.
- Pulse SRC_RAISE[2] for 1 cycle at edge n -> RAISE=1 at n+2; BASE+3 reads 8'h82; ACK -> SRC_ACK=4'b0100 for one cycle, PEND=0, RAISE low ≥1 cycle.
- Raise sources 3 and 1 in the same cycle -> first service CUR=1; after ACK and holdoff, RAISE again with VECTOR 8'h83; second ACK pulses SRC_ACK[3].
- Write MASK=8'h0E, then pulse source 0 -> PEND=8'h01, RAISE stays 0; write MASK=8'h0F -> RAISE=1 two cycles later.
- Level mode: MODE=8'h00, hold SRC_RAISE[1] high, ACK -> RAISE returns after holdoff; release the source -> PEND[1]=0 and RAISE drops with no ACK pulse.
- Edge on source 0 in the same cycle as a W1C of 8'h01 -> PEND[0] stays 1; assert RESET mid-RAISED -> RAISE=0 immediately, all state at reset values.
